// File: rtl/frame_sync_rx.sv
// -----------------------------------------------------------------------------
// frame_sync_rx
//
// Serial frame receiver. It searches the incoming bit stream for a fixed sync
// word, then deserializes a fixed-length payload into parallel words. It also
// flags frame boundaries and counts completed frames.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bit_in       serial data bit, sampled only while bit_en is high
//   bit_en       bit strobe, one received bit per cycle with bit_en high
//   data_out     last completed payload word, held until the next word
//   data_valid   one-cycle pulse when data_out updates
//   frame_start  one-cycle pulse after the sync word is detected
//   frame_end    one-cycle pulse together with data_valid of the last word
//   locked       high while the receiver is in the payload state
//   frame_cnt    completed-frame counter, wraps 255 -> 0
//   parity_err   parity error flag, valid only with data_valid
//
// Build option:
//   FRAME_SYNC_RX_PARITY_EN  each payload word is followed by an even-parity
//                            bit, and parity_err reports a mismatch. When the
//                            macro is undefined there is no parity bit and
//                            parity_err is tied to 0.
//
// States:
//   HUNT    | sliding-window search for SYNC_PATTERN
//   PAYLOAD | deserializing FRAME_WORDS payload words
// -----------------------------------------------------------------------------
module frame_sync_rx #(
    parameter int unsigned         SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'hA5,
    parameter int unsigned         PAYLOAD_W    = 8,
    parameter int unsigned         FRAME_WORDS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_en,
    output logic [PAYLOAD_W-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 locked,
    output logic [7:0]           frame_cnt,
    output logic                 parity_err
);

`ifdef FRAME_SYNC_RX_PARITY_EN
    // The whole word must still be held when its parity bit arrives.
    localparam int unsigned WORD_BITS = PAYLOAD_W + 1;
    localparam int unsigned DSR_W     = PAYLOAD_W;
`else
    // The last data bit is taken straight from bit_in, so only
    // PAYLOAD_W-1 earlier bits need to be stored.
    localparam int unsigned WORD_BITS = PAYLOAD_W;
    localparam int unsigned DSR_W     = PAYLOAD_W - 1;
`endif
    localparam int unsigned BCW = $clog2(WORD_BITS);
    localparam int unsigned WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_BITS - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t state, state_nxt;

    // The sync window keeps only the last SYNC_LEN-1 bits. The incoming bit
    // completes the SYNC_LEN-bit compare value.
    logic [SYNC_LEN-2:0]  sync_sr, sync_nxt;
    logic [SYNC_LEN-1:0]  sync_upd;
    logic [DSR_W-1:0]     data_sr, data_nxt;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [WCW-1:0]       word_cnt, word_cnt_nxt;
    logic [PAYLOAD_W-1:0] dout_nxt;
    logic                 dv_nxt;
    logic                 fs_nxt;
    logic                 fe_nxt;
    logic                 lock_nxt;
    logic [7:0]           fcnt_nxt;
    logic                 word_done;

`ifdef FRAME_SYNC_RX_PARITY_EN
    logic                 perr_nxt;
`else
    logic [PAYLOAD_W-1:0] word_upd;

    assign word_upd = {data_sr, bit_in};
`endif

    assign sync_upd = {sync_sr, bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sync_nxt     = sync_sr;
        data_nxt     = data_sr;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        dout_nxt     = data_out;
        dv_nxt       = 1'b0;
        fs_nxt       = 1'b0;
        fe_nxt       = 1'b0;
        fcnt_nxt     = frame_cnt;
        word_done    = 1'b0;
`ifdef FRAME_SYNC_RX_PARITY_EN
        perr_nxt     = 1'b0;
`endif

        unique case (state)
            HUNT: begin
                if (bit_en) begin
                    sync_nxt = sync_upd[SYNC_LEN-2:0];
                    if (sync_upd == SYNC_PATTERN) begin
                        state_nxt    = PAYLOAD;
                        bit_cnt_nxt  = '0;
                        word_cnt_nxt = '0;
                        fs_nxt       = 1'b1;
                    end
                end
            end

            PAYLOAD: begin
                if (bit_en) begin
                    bit_cnt_nxt = bit_cnt + BCW'(1);
`ifdef FRAME_SYNC_RX_PARITY_EN
                    if (bit_cnt == LAST_BIT) begin
                        // bit_in is the parity bit, and the word is already complete
                        word_done = 1'b1;
                        dout_nxt  = data_sr;
                        perr_nxt  = ^{data_sr, bit_in};
                    end else begin
                        data_nxt = {data_sr[PAYLOAD_W-2:0], bit_in};
                    end
`else
                    data_nxt = word_upd[DSR_W-1:0];
                    if (bit_cnt == LAST_BIT) begin
                        word_done = 1'b1;
                        dout_nxt  = word_upd;
                    end
`endif
                    if (word_done) begin
                        bit_cnt_nxt = '0;
                        dv_nxt      = 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            fe_nxt       = 1'b1;
                            fcnt_nxt     = frame_cnt + 8'd1;
                            state_nxt    = HUNT;
                            // Clear the window so that stale payload bits
                            // cannot combine into a false sync match.
                            sync_nxt     = '0;
                            word_cnt_nxt = '0;
                        end else begin
                            word_cnt_nxt = word_cnt + WCW'(1);
                        end
                    end
                end
            end

            default: begin
                state_nxt = HUNT;
            end
        endcase

        // locked follows the state directly, so it rises with frame_start
        // and falls with frame_end.
        lock_nxt = (state_nxt == PAYLOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr     <= '0;
            data_sr     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            locked      <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            sync_sr     <= sync_nxt;
            data_sr     <= data_nxt;
            bit_cnt     <= bit_cnt_nxt;
            word_cnt    <= word_cnt_nxt;
            data_out    <= dout_nxt;
            data_valid  <= dv_nxt;
            frame_start <= fs_nxt;
            frame_end   <= fe_nxt;
            locked      <= lock_nxt;
            frame_cnt   <= fcnt_nxt;
        end
    end

`ifdef FRAME_SYNC_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sync_rx.sv
`timescale 1ns/1ps
module tb_frame_sync_rx;

    localparam int SYNC_LEN         = 8;
    localparam int SYNC_PATTERN_INT = 'hA5;
    localparam int PAYLOAD_W        = 8;
    localparam int FRAME_WORDS      = 4;
`ifdef FRAME_SYNC_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WB = PAYLOAD_W + PAR;

    logic                 clk    = 1'b0;
    logic                 rst_n  = 1'b0;
    logic                 bit_in = 1'b0;
    logic                 bit_en = 1'b0;
    logic [PAYLOAD_W-1:0] data_out;
    logic                 data_valid;
    logic                 frame_start;
    logic                 frame_end;
    logic                 locked;
    logic [7:0]           frame_cnt;
    logic                 parity_err;

    frame_sync_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .locked      (locked),
        .frame_cnt   (frame_cnt),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // stimulus stream and per-bit expectations derived from it
    bit stim_q[$];
    bit e_fs[];
    bit e_dv[];
    bit e_fe[];
    bit e_lk[];
    bit e_pe[];
    int e_word[];
    int e_cnt[];

    // model view of held outputs
    int cur_dout = 0;
    int cur_cnt  = 0;
    bit cur_lk   = 0;

    task automatic push_bits(input int val, input int n);
        for (int i = n - 1; i >= 0; i--) stim_q.push_back(val[i]);
    endtask

    task automatic push_word(input int val);
        push_bits(val, PAYLOAD_W);
        if (PAR != 0) push_bits($countones(val) % 2, 1);
    endtask

    task automatic push_word_rand();
        push_bits(int'($urandom_range(0, (1 << PAYLOAD_W) - 1)), PAYLOAD_W);
        if (PAR != 0) push_bits(int'($urandom_range(0, 1)), 1);
    endtask

    // Walk the whole stream: slide a window looking for the sync value.
    // After a match, the next FRAME_WORDS*WB bits are payload. Each word
    // completes on its last bit, and the window restarts empty afterwards.
    task automatic build_expect();
        int n;
        int win;
        int i;
        int cnt;
        n   = stim_q.size();
        e_fs = new[n]; e_dv = new[n]; e_fe = new[n]; e_lk = new[n];
        e_pe = new[n]; e_word = new[n]; e_cnt = new[n];
        win = 0;
        i   = 0;
        cnt = cur_cnt;
        while (i < n) begin
            win = ((win << 1) | int'(stim_q[i])) & ((1 << SYNC_LEN) - 1);
            e_cnt[i] = cnt;
            if (win == SYNC_PATTERN_INT) begin
                int base;
                int last;
                e_fs[i] = 1'b1;
                e_lk[i] = 1'b1;
                base = i + 1;
                last = base + FRAME_WORDS * WB - 1;
                for (int k = base; k <= last && k < n; k++) begin
                    int off;
                    int w;
                    off = k - base;
                    w   = off / WB;
                    e_lk[k]  = (k != last);
                    e_cnt[k] = cnt;
                    if ((off % WB) == WB - 1) begin
                        int val;
                        int ones;
                        val = 0;
                        for (int j = 0; j < PAYLOAD_W; j++)
                            val = (val << 1) | int'(stim_q[base + w * WB + j]);
                        ones = $countones(val) + ((PAR != 0) ? int'(stim_q[k]) : 0);
                        e_dv[k]   = 1'b1;
                        e_word[k] = val;
                        e_pe[k]   = (PAR != 0) && ((ones % 2) == 1);
                        if (w == FRAME_WORDS - 1) begin
                            e_fe[k]  = 1'b1;
                            cnt      = (cnt + 1) % 256;
                            e_cnt[k] = cnt;
                        end
                    end
                end
                i   = last + 1;
                win = 0;
            end else begin
                i++;
            end
        end
    endtask

    // gap_mode: 0 = bit_en continuous, 1 = one strobe in four, 2 = random gaps
    task automatic run_stream(input int gap_mode);
        build_expect();
        for (int k = 0; k < stim_q.size(); k++) begin
            int gaps;
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                bit_en = 1'b0;
                @(posedge clk); #1;
                check_val("idle_dv", data_valid, 0);
                check_val("idle_fs", frame_start, 0);
                check_val("idle_fe", frame_end, 0);
                check_val("idle_locked", locked, cur_lk);
                check_val("idle_cnt", frame_cnt, cur_cnt);
            end
            bit_in = stim_q[k];
            bit_en = 1'b1;
            @(posedge clk); #1;
            bit_en = 1'b0;
            if (e_dv[k]) cur_dout = e_word[k];
            cur_lk  = e_lk[k];
            cur_cnt = e_cnt[k];
            check_val("data_valid", data_valid, e_dv[k]);
            check_val("frame_start", frame_start, e_fs[k]);
            check_val("frame_end", frame_end, e_fe[k]);
            check_val("locked", locked, cur_lk);
            check_val("data_out", data_out, cur_dout);
            check_val("frame_cnt", frame_cnt, cur_cnt);
            check_val("parity_err", parity_err, e_pe[k]);
        end
    endtask

    task automatic do_reset();
        bit_en = 1'b0;
        rst_n  = 1'b0;
        #2;
        check_val("rst_data_out", data_out, 0);
        check_val("rst_dv", data_valid, 0);
        check_val("rst_fs", frame_start, 0);
        check_val("rst_fe", frame_end, 0);
        check_val("rst_locked", locked, 0);
        check_val("rst_cnt", frame_cnt, 0);
        check_val("rst_perr", parity_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cur_dout = 0;
        cur_cnt  = 0;
        cur_lk   = 0;
    endtask

    task automatic push_clean();
        push_bits(SYNC_PATTERN_INT, SYNC_LEN);
        push_word('h12); push_word('h34); push_word('h56); push_word('h78);
    endtask

    initial begin
        do_reset();

        // clean frame followed by a few idle-line bits
        stim_q.delete();
        push_clean();
        push_bits(0, 4);
        run_stream(0);
        check_val("clean_cnt", frame_cnt, 1);
        check_val("clean_last", data_out, 'h78);

        // false and partial sync
        stim_q.delete();
        push_bits('hFF, 8); push_bits('h00, 8); push_bits('b1010, 4);
        push_bits(SYNC_PATTERN_INT, SYNC_LEN);
        push_word('h01); push_word('h02); push_word('h03); push_word('h04);
        run_stream(0);
        check_val("false_sync_cnt", frame_cnt, 2);

        // sparse strobes
        do_reset();
        stim_q.delete();
        push_clean();
        run_stream(1);
        check_val("gap_cnt", frame_cnt, 1);

        // reset in the middle of a frame, then a fresh frame
        do_reset();
        stim_q.delete();
        push_bits(SYNC_PATTERN_INT, SYNC_LEN);
        push_word('h12); push_word('h34); push_bits('h5, 3);
        run_stream(0);
        do_reset();
        stim_q.delete();
        push_bits(SYNC_PATTERN_INT, SYNC_LEN);
        push_word('hAA); push_word('hBB); push_word('hCC); push_word('hDD);
        run_stream(0);
        check_val("post_rst_cnt", frame_cnt, 1);

        // payload words that look like the sync word
        do_reset();
        stim_q.delete();
        push_bits(SYNC_PATTERN_INT, SYNC_LEN);
        for (int w = 0; w < FRAME_WORDS; w++) push_word(SYNC_PATTERN_INT);
        push_bits(SYNC_PATTERN_INT, SYNC_LEN);
        push_word('h11); push_word('h22); push_word('h33); push_word('h44);
        run_stream(0);
        check_val("sync_payload_cnt", frame_cnt, 2);

`ifdef FRAME_SYNC_RX_PARITY_EN
        // explicit parity cases: 0x12 has two ones, so a parity bit of 1 is wrong
        do_reset();
        stim_q.delete();
        push_bits(SYNC_PATTERN_INT, SYNC_LEN);
        push_bits('h12, 8); push_bits(1, 1);
        push_bits('h12, 8); push_bits(0, 1);
        push_word('h56); push_word('h78);
        run_stream(0);
`endif

        // random junk and frames with random strobe gaps
        do_reset();
        for (int it = 0; it < 8; it++) begin
            stim_q.delete();
            push_bits(int'($urandom), int'($urandom_range(0, 20)));
            for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
                push_bits(SYNC_PATTERN_INT, SYNC_LEN);
                for (int w = 0; w < FRAME_WORDS; w++) push_word_rand();
            end
            run_stream(2);
        end

        // 256 back-to-back frames: the counter wraps to 0
        do_reset();
        stim_q.delete();
        for (int f = 0; f < 256; f++) begin
            push_bits(SYNC_PATTERN_INT, SYNC_LEN);
            for (int w = 0; w < FRAME_WORDS; w++) push_word_rand();
        end
        run_stream(0);
        check_val("wrap_cnt", frame_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
